// File: rtl/count_seq_pkg.sv
// ============================================================================
// count_seq_pkg: shared state encoding, opcodes and default sizes for count_seq_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

package count_seq_pkg;

  localparam int DEFAULT_WIDTH   = 4;
  localparam int DEFAULT_PRESC_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0] OP_START      = 2'b00;
  localparam logic [1:0] OP_STOP       = 2'b01;
  localparam logic [1:0] OP_LOAD_LIMIT = 2'b10;
  localparam logic [1:0] OP_CLEAR      = 2'b11;

endpackage

`default_nettype wire

// File: rtl/count_seq_core.sv
// ============================================================================
// count_seq_core: WIDTH-bit up counter with synchronous clear and enable
// Revision: 1.0
// ============================================================================
`default_nettype none

module count_seq_core
  import count_seq_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  // Clear wins over enable; the increment wraps modulo 2^WIDTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (en)
      count <= count + WIDTH'(1);
  end

endmodule

`default_nettype wire

// File: rtl/count_seq_ctrl.sv
// ============================================================================
// count_seq_ctrl: command-driven one-shot/periodic up counter with terminal pulse
// Revision: 1.0  (optional prescaler: define COUNT_SEQ_PRESCALE_EN)
// ============================================================================
`default_nettype none

module count_seq_ctrl
  import count_seq_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int PRESC_W = DEFAULT_PRESC_W
) (
  input  logic               clk,
  input  logic               reset,
`ifdef COUNT_SEQ_PRESCALE_EN
  input  logic [PRESC_W-1:0] presc,
`endif
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [WIDTH-1:0]   cmd_data,
  input  logic               periodic,
  output logic [WIDTH-1:0]   count,
  output logic               busy,
  output logic               tc
);

  state_t             state;
  state_t             next_state;
  logic [WIDTH-1:0]   limit;
  logic               periodic_q;
  logic               presc_hit;
  logic               accept;
  logic               do_clear;
  logic               do_start;
  logic               do_stop;
  logic               start_fresh;
  logic               tick;
  logic               term;
  logic               count_clr;
  logic               count_en;
  logic               tc_next;

  assign accept      = cmd_valid && cmd_ready;
  assign do_clear    = accept && (cmd_op == OP_CLEAR);
  assign do_start    = accept && (cmd_op == OP_START);
  assign do_stop     = accept && (cmd_op == OP_STOP);
  assign start_fresh = do_start && ((state == S_IDLE) || (state == S_DONE));
  assign tick        = (state == S_RUN) && presc_hit;
  // Compare happens before the increment, so the terminal tick sees count == limit.
  assign term        = tick && (count == limit);

`ifdef COUNT_SEQ_PRESCALE_EN
  logic [PRESC_W-1:0] presc_cnt;

  assign presc_hit = (presc_cnt == presc);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      presc_cnt <= '0;
    else if (start_fresh || do_clear)
      presc_cnt <= '0;
    else if (state == S_RUN)
      presc_cnt <= presc_hit ? '0 : presc_cnt + PRESC_W'(1);
  end
`else
  // No prescaler: every RUN cycle is a tick (PRESC_W referenced to keep it bound).
  assign presc_hit = (PRESC_W != 0) || 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (do_clear)
      next_state = S_IDLE;
    else if (term)
      next_state = periodic_q ? (do_stop ? S_HOLD : S_RUN) : S_DONE;
    else begin
      case (state)
        S_IDLE:  if (do_start) next_state = S_RUN;
        S_RUN:   if (do_stop)  next_state = S_HOLD;
        S_HOLD:  if (do_start) next_state = S_RUN;
        S_DONE:  next_state = S_IDLE;
        default: next_state = S_IDLE;
      endcase
    end
  end

  always_comb begin
    cmd_ready = (state != S_DONE);
    busy      = (state == S_RUN) || (state == S_HOLD);
    count_clr = do_clear || start_fresh || (term && periodic_q);
    count_en  = tick && !term && !do_clear;
    tc_next   = term && !do_clear;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      limit      <= '1;
      periodic_q <= 1'b0;
      tc         <= 1'b0;
    end else begin
      tc <= tc_next;
      if (accept && (cmd_op == OP_LOAD_LIMIT))
        limit <= cmd_data;
      if (start_fresh)
        periodic_q <= periodic;
    end
  end

  count_seq_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk   (clk),
    .reset (reset),
    .clr   (count_clr),
    .en    (count_en),
    .count (count)
  );

endmodule

`default_nettype wire

// File: doc/count_seq_ctrl.md
COUNT_SEQ_CTRL -- requirements
Module: count_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter width in bits.
REQ-002 SHALL have parameter PRESC_W, default 4, prescaler width in bits; used only when COUNT_SEQ_PRESCALE_EN is defined.
REQ-003 SHALL have port clk  in  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port cmd_valid  in  1  command offered.
REQ-006 SHALL have port cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
REQ-007 SHALL have port cmd_op  in  2  opcode: 00 START, 01 STOP, 10 LOAD_LIMIT, 11 CLEAR.
REQ-008 SHALL have port cmd_data  in  WIDTH  new limit for LOAD_LIMIT; ignored otherwise.
REQ-009 SHALL have port periodic  in  1  mode, sampled on accepted START: 0 one-shot, 1 auto-wrap.
REQ-010 SHALL have port count  out  WIDTH  current counter value.
REQ-011 SHALL have port busy  out  1  high in RUN or HOLD.
REQ-012 SHALL have port tc  out  1  one-cycle terminal-count pulse.

Function
REQ-013 SHALL implement states IDLE, RUN, HOLD, DONE; cmd_ready = 0 in DONE, 1 otherwise.
REQ-014 SHALL, on START accepted in IDLE or DONE: count <= 0, latch periodic, go to RUN; first increment on the next edge (count=1 two cycles after acceptance).
REQ-015 SHALL, on START in HOLD, resume RUN without altering count; START in RUN is ignored.
REQ-016 SHALL, on STOP in RUN, go to HOLD with count frozen; STOP in other states is ignored.
REQ-017 SHALL, on LOAD_LIMIT in any accepting state, update limit on that edge; the new limit applies to the next compare.
REQ-018 SHALL, on CLEAR in any accepting state, set count <= 0 and go to IDLE.
REQ-019 SHALL, on each RUN tick, compare count to limit before incrementing: if unequal, count <= count+1 mod 2^WIDTH; if equal, assert tc next cycle.
REQ-020 SHALL, on terminal tick in one-shot mode, hold count at limit and go to DONE; DONE lasts exactly one cycle, then IDLE, count retained.
REQ-021 SHALL, on terminal tick in periodic mode, set count <= 0 and remain in RUN.
REQ-022 SHALL, when limit=0, produce tc on the first tick: one-shot goes to DONE with count 0; periodic pulses tc every tick.
REQ-023 SHALL, when the loaded limit is below the current count, count up through 2^WIDTH-1, wrap to 0, and terminate on reaching limit.
REQ-024 SHALL apply priority CLEAR > terminal event > STOP/START within a cycle; STOP on a periodic terminal tick yields HOLD with count 0; STOP on a one-shot terminal tick is ignored.

Reset
REQ-025 SHALL, on reset, set state IDLE, count 0, limit 2^WIDTH-1, busy 0, tc 0, cmd_ready 1, latched mode 0, prescaler 0.
REQ-026 SHALL abort any operation on reset mid-run, without emitting tc.

Configuration
REQ-027 SHALL, with COUNT_SEQ_PRESCALE_EN defined, add input presc[PRESC_W-1:0] and generate a RUN tick every presc+1 cycles.
REQ-028 SHALL, in that configuration, zero the prescaler on START-from-IDLE/DONE and on CLEAR, and hold it in HOLD.
REQ-029 SHALL, with COUNT_SEQ_PRESCALE_EN undefined, omit the presc port and tick every RUN cycle.

Structure
REQ-030 SHALL define state enum, opcode constants and WIDTH default in package count_seq_pkg.
REQ-031 SHALL instantiate sub-module count_seq_core, a WIDTH-bit up counter with clr and en inputs, for the count register.

Verification
REQ-032 One-shot, limit=3: LOAD 3, START -> count 0,1,2,3; tc one cycle; DONE one cycle with cmd_ready=0; IDLE with count=3.
REQ-033 Periodic, limit=2: START -> count 0,1,2,0,1,2; tc once per 3 cycles; busy held high.
REQ-034 Pause: STOP at count=5, wait 4 cycles, START -> count stays 5 in HOLD, then resumes 6.
REQ-035 Boundary: limit=15 with WIDTH=4, one-shot -> tc at count 15, no wrap; LOAD 1 at count 3 in periodic -> wraps 15->0->1, then tc.
REQ-036 Simultaneous and reset: STOP on periodic terminal tick -> tc, HOLD, count 0; reset asserted at count 7 -> count 0, IDLE, no tc.
REQ-037 Prescale (macro defined): presc=2, limit=1 -> count advances every 3 cycles; tc 6 cycles after RUN entry.
